atm_controller_param: RTL

Parametrised next-generation ATM transaction controller. It handles card detection, BCD PIN entry with configurable length and attempt limit, deposit and withdrawal against an internal balance register, a daily withdrawal limit, inactivity timeout and user cancel. It sits between the keypad/card-reader front end and the cash dispenser/display logic. All status outputs are registered.

---
 rtl/atm_controller_param.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/atm_controller_param.sv
// atm_controller_param: card detection, BCD PIN check with lockout, and
// deposit/withdrawal against an internal balance with a daily withdrawal limit.
module atm_controller_param #(
    parameter int unsigned           PIN_DIGITS     = 4,
    parameter logic [31:0]           PIN_CORRECTO   = 32'h0000_4756,
    parameter int unsigned           MAX_INTENTOS   = 3,
    parameter int unsigned           MONTO_W        = 32,
    parameter int unsigned           BALANCE_W      = 64,
    parameter logic [BALANCE_W-1:0]  BALANCE_INIT   = BALANCE_W'(4500),
    parameter logic [BALANCE_W-1:0]  LIMITE_RETIRO  = BALANCE_W'(20000),
    parameter int unsigned           TIMEOUT_CICLOS = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tarjeta_recibida,
    input  logic                 tipo_trans,
    input  logic                 add_digit,
    input  logic [3:0]           digito,
    input  logic                 monto_stb,
    input  logic [MONTO_W-1:0]   monto,
    input  logic                 cancelar,
    input  logic                 nuevo_dia,
    output logic                 balance_actualizado,
    output logic                 entregar_dinero,
    output logic                 pin_incorrecto,
    output logic                 fondos_insuficientes,
    output logic                 limite_excedido,
    output logic                 timeout,
    output logic                 advertencia,
    output logic                 bloqueo,
    output logic [BALANCE_W-1:0] balance,
    output logic [3:0]           intentos
);
    localparam int unsigned PIN_W = 4 * PIN_DIGITS;
    localparam int unsigned CNT_W = $clog2(PIN_DIGITS + 1);
    localparam int unsigned TMR_W = (TIMEOUT_CICLOS == 0) ? 1 : $clog2(TIMEOUT_CICLOS + 1);

    typedef enum logic [2:0] {
        ESPERANDO, INGRESO_PIN, VERIFICAR, DEPOSITO, RETIRO, BLOQUEO
    } state_t;

    state_t               state_q, state_d;
    logic [PIN_W-1:0]     pin_q, pin_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [BALANCE_W-1:0] balance_q, balance_d;
    logic [BALANCE_W-1:0] acum_q, acum_d;
    logic [3:0]           intentos_q, intentos_d;
    logic                 advertencia_q, advertencia_d;
    logic                 bloqueo_q, bloqueo_d;
    logic                 bal_upd_q, bal_upd_d;
    logic                 entregar_q, entregar_d;
    logic                 pin_inc_q, pin_inc_d;
    logic                 fondos_q, fondos_d;
    logic                 limite_q, limite_d;
    logic                 timeout_q, timeout_d;

    // Shared decode of the current cycle's inputs against state
    logic                 digit_ok, pin_last, pin_match, lock_hit, timer_hit, counting;
    logic [3:0]           intentos_inc;
    logic [BALANCE_W-1:0] monto_ext, acum_base;
    logic [BALANCE_W:0]   dep_sum, ret_sum;
    logic                 sin_fondos, excede;

    assign digit_ok     = add_digit && (digito <= 4'd9);
    assign pin_last     = digit_ok && (cnt_q == CNT_W'(PIN_DIGITS - 1));
    assign pin_match    = (pin_q == PIN_CORRECTO[PIN_W-1:0]);
    assign intentos_inc = intentos_q + 4'd1;
    assign lock_hit     = (intentos_inc == 4'(MAX_INTENTOS));
    assign timer_hit    = (TIMEOUT_CICLOS != 0) && (timer_q == TMR_W'(TIMEOUT_CICLOS - 1));
    assign monto_ext    = BALANCE_W'(monto);
    assign acum_base    = nuevo_dia ? '0 : acum_q;
    assign dep_sum      = {1'b0, balance_q} + {1'b0, monto_ext};
    assign ret_sum      = {1'b0, acum_base} + {1'b0, monto_ext};
    assign sin_fondos   = (monto_ext > balance_q);
    assign excede       = (ret_sum > {1'b0, LIMITE_RETIRO});
    // Timer runs only while staying in a waiting state with no keypad strobe
    assign counting     = (TIMEOUT_CICLOS != 0) && (state_d == state_q) &&
                          (state_q inside {INGRESO_PIN, DEPOSITO, RETIRO}) &&
                          !(state_q == INGRESO_PIN && add_digit);

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ESPERANDO;
            pin_q         <= '0;
            cnt_q         <= '0;
            timer_q       <= '0;
            balance_q     <= BALANCE_INIT;
            acum_q        <= '0;
            intentos_q    <= '0;
            advertencia_q <= 1'b0;
            bloqueo_q     <= 1'b0;
            bal_upd_q     <= 1'b0;
            entregar_q    <= 1'b0;
            pin_inc_q     <= 1'b0;
            fondos_q      <= 1'b0;
            limite_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pin_q         <= pin_d;
            cnt_q         <= cnt_d;
            timer_q       <= timer_d;
            balance_q     <= balance_d;
            acum_q        <= acum_d;
            intentos_q    <= intentos_d;
            advertencia_q <= advertencia_d;
            bloqueo_q     <= bloqueo_d;
            bal_upd_q     <= bal_upd_d;
            entregar_q    <= entregar_d;
            pin_inc_q     <= pin_inc_d;
            fondos_q      <= fondos_d;
            limite_q      <= limite_d;
            timeout_q     <= timeout_d;
        end
    end

    // Next-state selection; cancel beats strobes, strobes beat timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ESPERANDO:   if (tarjeta_recibida) state_d = INGRESO_PIN;
            INGRESO_PIN: begin
                if (cancelar)                     state_d = ESPERANDO;
                else if (pin_last)                state_d = VERIFICAR;
                else if (!add_digit && timer_hit) state_d = ESPERANDO;
            end
            VERIFICAR: begin
                if (cancelar)       state_d = ESPERANDO;
                else if (pin_match) state_d = tipo_trans ? RETIRO : DEPOSITO;
                else if (lock_hit)  state_d = BLOQUEO;
                else                state_d = INGRESO_PIN;
            end
            DEPOSITO, RETIRO: begin
                if (cancelar || monto_stb || timer_hit) state_d = ESPERANDO;
            end
            BLOQUEO:     state_d = BLOQUEO;
            default:     state_d = ESPERANDO;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        pin_d         = pin_q;
        cnt_d         = cnt_q;
        timer_d       = counting ? timer_q + TMR_W'(1) : '0;
        balance_d     = balance_q;
        acum_d        = nuevo_dia ? '0 : acum_q;
        intentos_d    = intentos_q;
        advertencia_d = advertencia_q;
        bloqueo_d     = (state_d == BLOQUEO);
        bal_upd_d     = 1'b0;
        entregar_d    = 1'b0;
        pin_inc_d     = 1'b0;
        fondos_d      = 1'b0;
        limite_d      = 1'b0;
        timeout_d     = 1'b0;
        case (state_q)
            ESPERANDO: begin
                if (tarjeta_recibida) begin
                    pin_d = '0;
                    cnt_d = '0;
                end
            end
            INGRESO_PIN: begin
                if (cancelar) begin
                    pin_d = '0;
                    cnt_d = '0;
                end else if (digit_ok) begin
                    pin_d = PIN_W'({pin_q, digito});
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (!add_digit && timer_hit) begin
                    timeout_d = 1'b1;
                    pin_d     = '0;
                    cnt_d     = '0;
                end
            end
            VERIFICAR: begin
                pin_d = '0;
                cnt_d = '0;
                if (!cancelar) begin
                    if (pin_match) begin
                        intentos_d    = '0;
                        advertencia_d = 1'b0;
                    end else begin
                        intentos_d = intentos_inc;
                        pin_inc_d  = 1'b1;
                        if (!lock_hit && intentos_inc == 4'(MAX_INTENTOS - 1))
                            advertencia_d = 1'b1;
                    end
                end
            end
            DEPOSITO: begin
                if (!cancelar && monto_stb) begin
                    balance_d = dep_sum[BALANCE_W] ? '1 : dep_sum[BALANCE_W-1:0];
                    bal_upd_d = 1'b1;
                end else if (!cancelar && timer_hit) begin
                    timeout_d = 1'b1;
                end
            end
            RETIRO: begin
                if (!cancelar && monto_stb) begin
                    if (sin_fondos) begin
                        fondos_d = 1'b1;
                    end else if (excede) begin
                        limite_d = 1'b1;
                    end else begin
                        balance_d  = balance_q - monto_ext;
                        acum_d     = ret_sum[BALANCE_W-1:0];
                        entregar_d = 1'b1;
                        bal_upd_d  = 1'b1;
                    end
                end else if (!cancelar && timer_hit) begin
                    timeout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign balance_actualizado  = bal_upd_q;
    assign entregar_dinero      = entregar_q;
    assign pin_incorrecto       = pin_inc_q;
    assign fondos_insuficientes = fondos_q;
    assign limite_excedido      = limite_q;
    assign timeout              = timeout_q;
    assign advertencia          = advertencia_q;
    assign bloqueo              = bloqueo_q;
    assign balance              = balance_q;
    assign intentos             = intentos_q;
endmodule
